// File: rtl/rc4_decrypt_core_if.sv
// Memory-side bus of the RC4 decrypt core: 256x8 S-box RAM, ciphertext ROM and plaintext RAM.
// All three memories are synchronous; the core owns addresses and write strobes.
interface rc4_decrypt_core_if #(
    parameter int unsigned MSG_AW = 5
) ();
    logic [7:0]        s_addr;
    logic [7:0]        s_wdata;
    logic              s_wren;
    logic [7:0]        s_rdata;
    logic [MSG_AW-1:0] rom_addr;
    logic [7:0]        rom_rdata;
    logic [MSG_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_wren;

    modport master (
        output s_addr,
        output s_wdata,
        output s_wren,
        input  s_rdata,
        output rom_addr,
        input  rom_rdata,
        output ram_addr,
        output ram_wdata,
        output ram_wren
    );

    modport slave (
        input  s_addr,
        input  s_wdata,
        input  s_wren,
        output s_rdata,
        input  rom_addr,
        output rom_rdata,
        input  ram_addr,
        input  ram_wdata,
        input  ram_wren
    );
endinterface

// File: rtl/rc4_decrypt_core.sv
// RC4 decryption core: fills S, runs the key schedule, then XORs the keystream with ROM bytes
// into RAM, optionally aborting on the first byte that is not a space or lowercase letter.
module rc4_decrypt_core #(
    parameter int unsigned KEY_BYTES   = 3,
    parameter int unsigned MSG_LEN     = 32,
    parameter int unsigned MSG_AW      = 5,
    parameter int unsigned CHECK_ASCII = 1
) (
    input  logic                   CLOCK_50,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   busy,
    output logic                   done,
    output logic                   valid,
    rc4_decrypt_core_if.master     mem
);

    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0]     KIDX_LAST = KW'(KEY_BYTES - 1);
    localparam logic [MSG_AW-1:0] K_LAST    = MSG_AW'(MSG_LEN - 1);

    typedef enum logic [4:0] {
        StIdle,
        StFill,
        StKsaAddrI,
        StKsaWaitI,
        StKsaCapI,
        StKsaWaitJ,
        StKsaCapJ,
        StKsaWrJ,
        StPrgaAddrI,
        StPrgaWaitI,
        StPrgaCapI,
        StPrgaWaitJ,
        StPrgaCapJ,
        StPrgaWrJ,
        StPrgaAddrF,
        StPrgaWaitF,
        StPrgaCapF,
        StPrgaWr,
        StDone
    } state_e;

    state_e                 r_state;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [7:0]             r_si;
    logic [7:0]             r_sj;
    logic [KW-1:0]          r_kidx;
    logic [MSG_AW-1:0]      r_k;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_valid;
    logic [7:0]             r_s_addr;
    logic [7:0]             r_s_wdata;
    logic                   r_s_wren;
    logic [MSG_AW-1:0]      r_rom_addr;
    logic [MSG_AW-1:0]      r_ram_addr;
    logic [7:0]             r_ram_wdata;
    logic                   r_ram_wren;

    logic [7:0] w_key_byte;
    logic [7:0] w_j_ksa;
    logic [7:0] w_j_prga;
    logic [7:0] w_p;
    logic       w_p_ok;

    // Key byte selected by the rolling index; byte 0 sits in the most significant lane.
    always_comb begin
        w_key_byte = 8'h00;
        for (int b = 0; b < int'(KEY_BYTES); b++) begin
            if (r_kidx == KW'(b)) begin
                w_key_byte = r_key[8*(int'(KEY_BYTES)-1-b) +: 8];
            end
        end
    end

    always_comb begin
        w_j_ksa  = r_j + mem.s_rdata + w_key_byte;
        w_j_prga = r_j + mem.s_rdata;
        w_p      = mem.s_rdata ^ mem.rom_rdata;
        w_p_ok   = (w_p == 8'h20) || ((w_p >= 8'h61) && (w_p <= 8'h7A));
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_key       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_kidx      <= '0;
            r_k         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_s_wren    <= 1'b0;
            r_rom_addr  <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_wren  <= 1'b0;
        end else begin
            // Write strobes are single-cycle unless a write state re-asserts them.
            r_s_wren   <= 1'b0;
            r_ram_wren <= 1'b0;

            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_key   <= key;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_i     <= '0;
                        r_state <= StFill;
                    end
                end

                StFill: begin
                    r_s_addr  <= r_i;
                    r_s_wdata <= r_i;
                    r_s_wren  <= 1'b1;
                    r_i       <= r_i + 8'd1;
                    if (r_i == 8'hFF) begin
                        r_j     <= '0;
                        r_kidx  <= '0;
                        r_state <= StKsaAddrI;
                    end
                end

                StKsaAddrI: begin
                    r_s_addr <= r_i;
                    r_state  <= StKsaWaitI;
                end

                StKsaWaitI: r_state <= StKsaCapI;

                StKsaCapI: begin
                    r_si     <= mem.s_rdata;
                    r_j      <= w_j_ksa;
                    r_s_addr <= w_j_ksa;
                    r_kidx   <= (r_kidx == KIDX_LAST) ? '0 : r_kidx + 1'b1;
                    r_state  <= StKsaWaitJ;
                end

                StKsaWaitJ: r_state <= StKsaCapJ;

                StKsaCapJ: begin
                    r_sj      <= mem.s_rdata;
                    r_s_addr  <= r_i;
                    r_s_wdata <= mem.s_rdata;
                    r_s_wren  <= 1'b1;
                    r_state   <= StKsaWrJ;
                end

                StKsaWrJ: begin
                    r_s_addr  <= r_j;
                    r_s_wdata <= r_si;
                    r_s_wren  <= 1'b1;
                    if (r_i == 8'hFF) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_state <= StPrgaAddrI;
                    end else begin
                        r_i     <= r_i + 8'd1;
                        r_state <= StKsaAddrI;
                    end
                end

                StPrgaAddrI: begin
                    r_i      <= r_i + 8'd1;
                    r_s_addr <= r_i + 8'd1;
                    r_state  <= StPrgaWaitI;
                end

                StPrgaWaitI: r_state <= StPrgaCapI;

                StPrgaCapI: begin
                    r_si     <= mem.s_rdata;
                    r_j      <= w_j_prga;
                    r_s_addr <= w_j_prga;
                    r_state  <= StPrgaWaitJ;
                end

                StPrgaWaitJ: r_state <= StPrgaCapJ;

                StPrgaCapJ: begin
                    r_sj      <= mem.s_rdata;
                    r_s_addr  <= r_i;
                    r_s_wdata <= mem.s_rdata;
                    r_s_wren  <= 1'b1;
                    r_state   <= StPrgaWrJ;
                end

                StPrgaWrJ: begin
                    r_s_addr  <= r_j;
                    r_s_wdata <= r_si;
                    r_s_wren  <= 1'b1;
                    r_state   <= StPrgaAddrF;
                end

                // Swapped values sum to the same index, so the pre-swap copies serve here.
                StPrgaAddrF: begin
                    r_s_addr   <= r_si + r_sj;
                    r_rom_addr <= r_k;
                    r_state    <= StPrgaWaitF;
                end

                StPrgaWaitF: r_state <= StPrgaCapF;

                StPrgaCapF: begin
                    if ((CHECK_ASCII != 0) && !w_p_ok) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_ram_addr  <= r_k;
                        r_ram_wdata <= w_p;
                        r_ram_wren  <= 1'b1;
                        r_state     <= StPrgaWr;
                    end
                end

                StPrgaWr: begin
                    if (r_k == K_LAST) begin
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= StPrgaAddrI;
                    end
                end

                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign valid         = r_valid;
    assign mem.s_addr    = r_s_addr;
    assign mem.s_wdata   = r_s_wdata;
    assign mem.s_wren    = r_s_wren;
    assign mem.rom_addr  = r_rom_addr;
    assign mem.ram_addr  = r_ram_addr;
    assign mem.ram_wdata = r_ram_wdata;
    assign mem.ram_wren  = r_ram_wren;

endmodule

// File: doc/rc4_decrypt_core.md
RC4_DECRYPT_CORE -- requirements
Module: rc4_decrypt_core

Interface
REQ-001 SHALL have parameter KEY_BYTES, default 3, meaning the secret key length in bytes (1..32).
REQ-002 SHALL have parameter MSG_LEN, default 32, meaning the message length in bytes (1..2^MSG_AW).
REQ-003 SHALL have parameter MSG_AW, default 5, meaning the ROM/RAM address width.
REQ-004 SHALL have parameter CHECK_ASCII, default 1, meaning plaintext validity check enable (1 = abort on invalid byte).
REQ-005 SHALL have port CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have port start  in  1  begin-decrypt request.
REQ-008 SHALL have port key  in  8*KEY_BYTES  secret key; byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB first).
REQ-009 SHALL have port busy  out  1  high from accepted start until done.
REQ-010 SHALL have port done  out  1  high in DONE state.
REQ-011 SHALL have port valid  out  1  result flag, meaningful while done=1.
REQ-012 SHALL have ports s_addr out 8, s_wdata out 8, s_wren out 1, s_rdata in 8 for the 256x8 S memory.
REQ-013 SHALL have ports rom_addr out MSG_AW, rom_rdata in 8 for the ciphertext ROM.
REQ-014 SHALL have ports ram_addr out MSG_AW, ram_wdata out 8, ram_wren out 1 for the plaintext RAM.

Function
REQ-015 SHALL treat all memories as synchronous: the core captures rdata two rising edges after driving the address, inserting one wait state per read.
REQ-016 SHALL accept start only in IDLE or DONE, latch key into an internal register on that edge, clear valid, set busy, and enter FILL; start while busy SHALL be ignored.
REQ-017 SHALL use the following state sequence: IDLE -> FILL -> KSA loop -> PRGA loop -> DONE.
REQ-018 SHALL, in FILL, write S[i]=i for i=0..255, one write per cycle (256 cycles, s_wren=1), then set i=0 and j=0.
REQ-019 SHALL perform the KSA loop: for i=0..255, read S[i]; set j=(j+S[i]+key[i mod KEY_BYTES]) mod 256; read S[j]; write S[i]=old S[j], then write S[j]=old S[i], on consecutive cycles.
REQ-020 SHALL keep i and j as 8-bit values with natural wrap; the loop exit SHALL be detected after i=255 (9-bit counter or terminal flag), not by wrap to 0.
REQ-021 SHALL implement i mod KEY_BYTES with a separate 0..KEY_BYTES-1 counter that resets at KSA start, not with a divider.
REQ-022 SHALL, before PRGA, set i=0, j=0, and k=0.
REQ-023 SHALL perform the PRGA loop for each k: i=i+1; read S[i]; j=j+S[i]; read S[j]; swap as in REQ-019; read S[(S[i]+S[j]) mod 256] into f; read rom[k]; p = f XOR rom[k].
REQ-024 SHALL, if CHECK_ASCII=1 and p is not 0x20 and not in 0x61..0x7A, suppress the RAM write, set valid=0, and enter DONE.
REQ-025 SHALL otherwise write ram[k]=p for exactly one cycle (ram_wren=1), then increment k; after k=MSG_LEN-1 it SHALL set valid=1 and enter DONE.
REQ-026 SHALL hold s_wren=0 and ram_wren=0 in every state that is not a write cycle.
REQ-027 SHALL have an S-memory write on the same cycle as the swap never overlap a read; if i==j, both swap writes SHALL still occur with identical data.
REQ-028 SHALL hold done and valid in DONE until the next accepted start; start in DONE SHALL restart from FILL.

Reset
REQ-029 SHALL, with rst_n=0 at a clock edge, go to IDLE with busy=0, done=0, valid=0, s_wren=0, ram_wren=0, and all addresses and data 0; this SHALL apply in any state, including mid-loop.
REQ-030 SHALL, after reset release, remain in IDLE until start; no memory writes SHALL occur before start.

Verification
REQ-031 SHALL verify the fill phase: start with key=0x000000 -> 256 consecutive s_wren cycles, with s_addr=s_wdata=0,1,...,255.
REQ-032 SHALL verify a known vector: KEY_BYTES=3, MSG_LEN=9, CHECK_ASCII=0, key=0x4B6579 ("Key"), ROM=BB F3 16 E8 D9 40 AF 0A D3 -> RAM=50 6C 61 69 6E 74 65 78 74 ("Plaintext"), valid=1, done=1.
REQ-033 SHALL verify the abort path: same setup with CHECK_ASCII=1 -> first p=0x50 is invalid, so no ram_wren pulse occurs, done=1, and valid=0.
REQ-034 SHALL verify ignored start: start pulsed again mid-KSA with a different key -> output is unchanged from REQ-032 and busy stays high.
REQ-035 SHALL verify reset mid-operation: rst_n=0 for 1 cycle during PRGA k=4 -> next cycle busy=0, done=0, no writes; a fresh start then reproduces REQ-032 exactly.
REQ-036 SHALL verify restart from DONE: start in DONE with key=0x4B6579 -> identical RAM contents and identical cycle count to the first run.
